instr_fetch_decode: RTL and testbench

- Front end of the 8-bit CPU; sits between the instruction ROM and the execute stage.
- Drives the ROM address (PC) and receives the instruction byte pair opcode1/opcode2 from the ROM combinationally in the same cycle.
- Decodes the pair into register and immediate fields and presents them to execute through a one-entry valid/ready output register.
- Handles PC increment, wrap-around, JMP, HALT, illegal opcodes and redirect/flush from execute.

---
 rtl/cpu_isa_pkg.sv | 33 +++
 rtl/instr_fetch_decode_if.sv | 32 +++
 rtl/instr_decoder.sv | 34 +++
 rtl/instr_fetch_decode.sv | 91 +++++++++
 tb/tb_instr_fetch_decode.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_isa_pkg.sv
// ISA definitions for the 8-bit CPU front end: opcodes, decoded-instruction
// record and fetch FSM states.
package cpu_isa_pkg;

    localparam int unsigned INSTR_BYTES = 2;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_JMP  = 4'h4,
        OP_ADD  = 4'h8,
        OP_SUB  = 4'h9,
        OP_HALT = 4'hF
    } opcode_e;

    // op carries the raw nibble so undefined opcodes remain visible downstream
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [7:0] imm;
        logic       illegal;
    } decoded_instr_t;

    typedef enum logic {
        FS_RUN,
        FS_HALT
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_decode_if.sv
// ROM, decode-output handshake and redirect signals of the fetch/decode stage.
interface instr_fetch_decode_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] rom_address;
    logic [7:0]        opcode1;
    logic [7:0]        opcode2;
    logic              dec_valid;
    logic              dec_ready;
    logic [3:0]        dec_op;
    logic [3:0]        dec_rd;
    logic [3:0]        dec_rs1;
    logic [3:0]        dec_rs2;
    logic [7:0]        dec_imm;
    logic [ADDR_W-1:0] dec_pc;
    logic              dec_illegal;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted;

    modport master (
        output rom_address, dec_valid, dec_op, dec_rd, dec_rs1, dec_rs2,
               dec_imm, dec_pc, dec_illegal, halted,
        input  opcode1, opcode2, dec_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  rom_address, dec_valid, dec_op, dec_rd, dec_rs1, dec_rs2,
               dec_imm, dec_pc, dec_illegal, halted,
        output opcode1, opcode2, dec_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_decoder.sv
// Combinational decode of a 2-byte instruction into register/immediate fields;
// fields an opcode does not use are driven to zero.
module instr_decoder
    import cpu_isa_pkg::*;
(
    input  logic [7:0]     opcode1_i,
    input  logic [7:0]     opcode2_i,
    output decoded_instr_t dec_o
);

    always_comb begin
        dec_o    = '0;
        dec_o.op = opcode1_i[7:4];
        case (opcode1_i[7:4])
            OP_NOP, OP_HALT: ;
            OP_LDI, OP_LD: begin
                dec_o.rd  = opcode1_i[3:0];
                dec_o.imm = opcode2_i;
            end
            OP_ST: begin
                dec_o.rs1 = opcode1_i[3:0];
                dec_o.imm = opcode2_i;
            end
            OP_JMP: dec_o.imm = opcode2_i;
            OP_ADD, OP_SUB: begin
                dec_o.rs1 = opcode1_i[3:0];
                dec_o.rs2 = opcode2_i[7:4];
                dec_o.rd  = opcode2_i[3:0];
            end
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: PC, RUN/HALT fetch FSM and a one-entry valid/ready
// output register feeding the execute stage.
module instr_fetch_decode
    import cpu_isa_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_fetch_decode_if.master  bus
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] dpc_q, dpc_d;
    decoded_instr_t    out_q, out_d;
    logic              valid_q, valid_d;
    decoded_instr_t    dec_w;
    logic              advance;

    instr_decoder u_decoder (
        .opcode1_i (bus.opcode1),
        .opcode2_i (bus.opcode2),
        .dec_o     (dec_w)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FS_RUN;
            pc_q    <= RESET_PC;
            dpc_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            dpc_q   <= dpc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        dpc_d   = dpc_q;
        out_d   = out_q;
        valid_d = valid_q;
        advance = 1'b0;
        // Redirect wins over everything, including acceptance of the pending entry
        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_pc;
            valid_d = 1'b0;
            state_d = FS_RUN;
        end else begin
            case (state_q)
                FS_RUN: begin
                    advance = !valid_q || bus.dec_ready;
                    if (advance) begin
                        out_d   = dec_w;
                        dpc_d   = pc_q;
                        valid_d = 1'b1;
                        if (dec_w.illegal || dec_w.op == OP_HALT) begin
                            state_d = FS_HALT;
                        end else if (dec_w.op == OP_JMP) begin
                            pc_d = ADDR_W'(dec_w.imm);
                        end else begin
                            pc_d = pc_q + ADDR_W'(INSTR_BYTES);
                        end
                    end
                end
                FS_HALT: begin
                    if (valid_q && bus.dec_ready) valid_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_address = pc_q;
    assign bus.dec_valid   = valid_q;
    assign bus.dec_op      = out_q.op;
    assign bus.dec_rd      = out_q.rd;
    assign bus.dec_rs1     = out_q.rs1;
    assign bus.dec_rs2     = out_q.rs2;
    assign bus.dec_imm     = out_q.imm;
    assign bus.dec_pc      = dpc_q;
    assign bus.dec_illegal = out_q.illegal;
    assign bus.halted      = (state_q == FS_HALT);

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: a vector table for straight-line,
// backpressure, JMP, redirect and wrap cases, plus HALT/illegal/reset sequences.
module tb_instr_fetch_decode;

    typedef struct packed {
        logic       valid;
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [7:0] imm;
        logic [7:0] pc;
        logic       ill;
        logic       halt;
        logic [7:0] rom;
    } obs_t;

    typedef struct {
        logic       ready;
        logic       redir;
        logic [7:0] rpc;
        obs_t       exp;
    } vec_t;

    localparam int unsigned NVEC = 19;

    logic       clk;
    logic       reset;
    logic [7:0] rom [256];
    int         nvec;
    int         nmis;
    vec_t       vecs [NVEC];

    instr_fetch_decode_if #(.ADDR_W(8)) bus ();

    instr_fetch_decode #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.opcode1 = rom[bus.rom_address];
    assign bus.opcode2 = (bus.rom_address == 8'hFF) ? 8'h00 : rom[bus.rom_address + 8'd1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic v, input logic [3:0] op, input logic [3:0] rd,
                                input logic [3:0] rs1, input logic [3:0] rs2,
                                input logic [7:0] imm, input logic [7:0] pc,
                                input logic ill, input logic halt, input logic [7:0] rom_a);
        obs_t o;
        o.valid = v;   o.op  = op;  o.rd   = rd;   o.rs1 = rs1; o.rs2 = rs2;
        o.imm   = imm; o.pc  = pc;  o.ill  = ill;  o.halt = halt; o.rom = rom_a;
        return o;
    endfunction

    task automatic check(input string name, input obs_t e);
        obs_t a;
        a.valid = bus.dec_valid;  a.op  = bus.dec_op;  a.rd  = bus.dec_rd;
        a.rs1   = bus.dec_rs1;    a.rs2 = bus.dec_rs2; a.imm = bus.dec_imm;
        a.pc    = bus.dec_pc;     a.ill = bus.dec_illegal;
        a.halt  = bus.halted;     a.rom = bus.rom_address;
        nvec++;
        if (a !== e) begin
            nmis++;
            $display("FAIL %s: got v=%0b op=%h rd=%h rs1=%h rs2=%h imm=%h pc=%h ill=%0b halt=%0b rom=%h | expected v=%0b op=%h rd=%h rs1=%h rs2=%h imm=%h pc=%h ill=%0b halt=%0b rom=%h",
                     name, a.valid, a.op, a.rd, a.rs1, a.rs2, a.imm, a.pc, a.ill, a.halt, a.rom,
                     e.valid, e.op, e.rd, e.rs1, e.rs2, e.imm, e.pc, e.ill, e.halt, e.rom);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic enter_reset();
        reset              = 1'b1;
        bus.dec_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 8'h00;
        clear_rom();
    endtask

    task automatic leave_reset();
        step();
        reset         = 1'b0;
        bus.dec_ready = 1'b1;
    endtask

    initial begin
        obs_t z0;
        nvec = 0;
        nmis = 0;
        z0   = mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 0, 0, 8'h00);

        enter_reset();
        rom[8'h04] = 8'h10; rom[8'h05] = 8'hFF;
        rom[8'h06] = 8'h11; rom[8'h07] = 8'h01;
        rom[8'h08] = 8'h12; rom[8'h09] = 8'hF8;
        rom[8'h0A] = 8'h80; rom[8'h0B] = 8'h13;
        rom[8'h0C] = 8'h33; rom[8'h0D] = 8'h82;
        rom[8'h40] = 8'h15; rom[8'h41] = 8'h5A;
        rom[8'h42] = 8'h40; rom[8'h43] = 8'h20;
        rom[8'h20] = 8'h17; rom[8'h21] = 8'h77;
        rom[8'h22] = 8'h6A; rom[8'h23] = 8'h33;
        rom[8'hFF] = 8'h19;

        //               ready redir rpc      v  op     rd     rs1    rs2    imm    pc     il hl rom
        vecs[0]  = '{1'b1, 1'b0, 8'h00, mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 0, 0, 8'h02)};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h02, 0, 0, 8'h04)};
        vecs[2]  = '{1'b1, 1'b0, 8'h00, mk(1, 4'h1, 4'h0, 4'h0, 4'h0, 8'hFF, 8'h04, 0, 0, 8'h06)};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, mk(1, 4'h1, 4'h0, 4'h0, 4'h0, 8'hFF, 8'h04, 0, 0, 8'h06)};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, mk(1, 4'h1, 4'h0, 4'h0, 4'h0, 8'hFF, 8'h04, 0, 0, 8'h06)};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, mk(1, 4'h1, 4'h0, 4'h0, 4'h0, 8'hFF, 8'h04, 0, 0, 8'h06)};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, mk(1, 4'h1, 4'h1, 4'h0, 4'h0, 8'h01, 8'h06, 0, 0, 8'h08)};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, mk(1, 4'h1, 4'h2, 4'h0, 4'h0, 8'hF8, 8'h08, 0, 0, 8'h0A)};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, mk(1, 4'h8, 4'h3, 4'h0, 4'h1, 8'h00, 8'h0A, 0, 0, 8'h0C)};
        vecs[9]  = '{1'b1, 1'b0, 8'h00, mk(1, 4'h3, 4'h0, 4'h3, 4'h0, 8'h82, 8'h0C, 0, 0, 8'h0E)};
        vecs[10] = '{1'b1, 1'b1, 8'h40, mk(0, 4'h3, 4'h0, 4'h3, 4'h0, 8'h82, 8'h0C, 0, 0, 8'h40)};
        vecs[11] = '{1'b1, 1'b0, 8'h00, mk(1, 4'h1, 4'h5, 4'h0, 4'h0, 8'h5A, 8'h40, 0, 0, 8'h42)};
        vecs[12] = '{1'b1, 1'b0, 8'h00, mk(1, 4'h4, 4'h0, 4'h0, 4'h0, 8'h20, 8'h42, 0, 0, 8'h20)};
        vecs[13] = '{1'b1, 1'b0, 8'h00, mk(1, 4'h1, 4'h7, 4'h0, 4'h0, 8'h77, 8'h20, 0, 0, 8'h22)};
        vecs[14] = '{1'b1, 1'b0, 8'h00, mk(1, 4'h6, 4'h0, 4'h0, 4'h0, 8'h00, 8'h22, 1, 1, 8'h22)};
        vecs[15] = '{1'b1, 1'b0, 8'h00, mk(0, 4'h6, 4'h0, 4'h0, 4'h0, 8'h00, 8'h22, 1, 1, 8'h22)};
        vecs[16] = '{1'b1, 1'b1, 8'hFF, mk(0, 4'h6, 4'h0, 4'h0, 4'h0, 8'h00, 8'h22, 1, 0, 8'hFF)};
        vecs[17] = '{1'b1, 1'b0, 8'h00, mk(1, 4'h1, 4'h9, 4'h0, 4'h0, 8'h00, 8'hFF, 0, 0, 8'h01)};
        vecs[18] = '{1'b1, 1'b0, 8'h00, mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h01, 0, 0, 8'h03)};

        step();
        check("reset_state", z0);
        reset = 1'b0;
        for (int unsigned i = 0; i < NVEC; i++) begin
            bus.dec_ready      = vecs[i].ready;
            bus.redirect_valid = vecs[i].redir;
            bus.redirect_pc    = vecs[i].rpc;
            step();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // HALT at pc=6, held once, accepted, then released by redirect to 0
        enter_reset();
        rom[8'h06] = 8'hF0;
        leave_reset();
        step(); check("h_pc0", mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 0, 0, 8'h02));
        step(); check("h_pc2", mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h02, 0, 0, 8'h04));
        step(); check("h_pc4", mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h04, 0, 0, 8'h06));
        step(); check("h_halt", mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 8'h06, 0, 1, 8'h06));
        bus.dec_ready = 1'b0;
        step(); check("h_hold", mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 8'h06, 0, 1, 8'h06));
        bus.dec_ready = 1'b1;
        step(); check("h_accept", mk(0, 4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 8'h06, 0, 1, 8'h06));
        step(); check("h_frozen", mk(0, 4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 8'h06, 0, 1, 8'h06));
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h00;
        step(); check("h_redir", mk(0, 4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 8'h06, 0, 0, 8'h00));
        bus.redirect_valid = 1'b0;
        step(); check("h_resume", mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 0, 0, 8'h02));

        // Illegal opcode 5 at pc=4
        enter_reset();
        rom[8'h04] = 8'h5C; rom[8'h05] = 8'h77;
        leave_reset();
        step(); check("i_pc0", mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 0, 0, 8'h02));
        step(); check("i_pc2", mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h02, 0, 0, 8'h04));
        step(); check("i_illegal", mk(1, 4'h5, 4'h0, 4'h0, 4'h0, 8'h00, 8'h04, 1, 1, 8'h04));
        step(); check("i_accept", mk(0, 4'h5, 4'h0, 4'h0, 4'h0, 8'h00, 8'h04, 1, 1, 8'h04));

        // JMP at pc=2 to 0x20, run to 0x30, then asynchronous reset mid-stream
        enter_reset();
        rom[8'h02] = 8'h40; rom[8'h03] = 8'h20;
        rom[8'h30] = 8'h1A; rom[8'h31] = 8'hAB;
        leave_reset();
        step(); check("r_pc0", mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 0, 0, 8'h02));
        step(); check("r_jmp", mk(1, 4'h4, 4'h0, 4'h0, 4'h0, 8'h20, 8'h02, 0, 0, 8'h20));
        for (int unsigned k = 0; k < 8; k++) begin
            step();
            check($sformatf("r_nop%0d", k),
                  mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'(8'h20 + 2 * k), 0, 0, 8'(8'h22 + 2 * k)));
        end
        step(); check("r_pc30", mk(1, 4'h1, 4'hA, 4'h0, 4'h0, 8'hAB, 8'h30, 0, 0, 8'h32));
        #2 reset = 1'b1;
        #1 check("r_async", z0);
        step(); check("r_held", z0);
        reset = 1'b0;
        step(); check("r_restart", mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 0, 0, 8'h02));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
